// File: rtl/deinterleaver_pkg.sv
// rtl/deinterleaver_pkg.sv - shared QPP constants, bank/FSM encodings and modular add helper
package deinterleaver_pkg;

  localparam int AW = 13;
  localparam int K_SMALL_I = 1056;
  localparam int K_LARGE_I = 6144;
  localparam int F1_S = 17;
  localparam int F2_S = 66;
  localparam int F1_L = 263;
  localparam int F2_L = 480;

  localparam logic [AW-1:0] K_SMALL = AW'(K_SMALL_I);
  localparam logic [AW-1:0] K_LARGE = AW'(K_LARGE_I);
  // g(0) = f1+f2 and the per-step increment 2*f2, both already reduced mod K
  localparam logic [AW-1:0] G0_S   = AW'((F1_S + F2_S) % K_SMALL_I);
  localparam logic [AW-1:0] G0_L   = AW'((F1_L + F2_L) % K_LARGE_I);
  localparam logic [AW-1:0] D2F2_S = AW'((2 * F2_S) % K_SMALL_I);
  localparam logic [AW-1:0] D2F2_L = AW'((2 * F2_L) % K_LARGE_I);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;
  typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} wr_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} rd_state_e;

  // both operands are already < k, so one conditional subtract is enough
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic [AW-1:0] k);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[AW-1:0];
  endfunction

endpackage

// File: rtl/deinterleaver_qpp_addr_gen.sv
// rtl/deinterleaver_qpp_addr_gen.sv - recursive QPP address generator (no ROM, no multiplier)
module deinterleaver_qpp_addr_gen
  import deinterleaver_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          advance,
  input  logic          size_in,
  output logic [AW-1:0] pi,
  output logic          last,
  output logic          size
);

  logic          size_q, size_d;
  logic [AW-1:0] i_q, i_d, pi_q, pi_d, g_q, g_d;
  logic [AW-1:0] k_cur, k_new, g0_new, d2_new;

  always_comb begin
    k_cur  = size_q ? K_LARGE : K_SMALL;
    k_new  = size_in ? K_LARGE : K_SMALL;
    g0_new = size_in ? G0_L : G0_S;
    d2_new = size_in ? D2F2_L : D2F2_S;
    size_d = size_q;
    i_d    = i_q;
    pi_d   = pi_q;
    g_d    = g_q;
    // init consumes index 0 (address 0) in the same cycle, so load the state for i=1
    if (init) begin
      size_d = size_in;
      i_d    = AW'(1);
      pi_d   = g0_new;
      g_d    = mod_add(g0_new, d2_new, k_new);
    end else if (advance) begin
      i_d  = i_q + AW'(1);
      pi_d = mod_add(pi_q, g_q, k_cur);
      g_d  = mod_add(g_q, size_q ? D2F2_L : D2F2_S, k_cur);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      size_q <= 1'b0;
      i_q    <= '0;
      pi_q   <= '0;
      g_q    <= '0;
    end else begin
      size_q <= size_d;
      i_q    <= i_d;
      pi_q   <= pi_d;
      g_q    <= g_d;
    end
  end

  assign pi   = pi_q;
  assign last = (i_q == k_cur - AW'(1));
  assign size = size_q;

endmodule

// File: rtl/deinterleaver.sv
// rtl/deinterleaver.sv - QPP deinterleaver with ping-pong 1-bit banks
module deinterleaver
  import deinterleaver_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  input  logic data_valid,
  input  logic blk_start,
  input  logic blk_size,
  output logic in_ready,
  output logic data_out,
  output logic data_ready,
  output logic out_start,
  output logic done,
  output logic err
);

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  bank_state_e bank0_q, bank0_d, bank1_q, bank1_d;
  logic [1:0]  bsize_q, bsize_d;
  logic        wsel_q, wsel_d, rsel_q, rsel_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic        data_out_q, data_out_d, data_ready_q, data_ready_d;
  logic        out_start_q, out_start_d, done_q, done_d, err_q, err_d;

  logic bank0_mem [0:K_LARGE_I-1];
  logic bank1_mem [0:K_LARGE_I-1];

  logic          accept, gen_init, gen_adv, gen_last, gen_size, we, fill_done;
  logic [AW-1:0] gen_pi, waddr, rk;
  bank_state_e   wr_bank_st, rd_bank_st;

  deinterleaver_qpp_addr_gen u_gen (
    .clk     (clk),
    .reset   (reset),
    .init    (gen_init),
    .advance (gen_adv),
    .size_in (blk_size),
    .pi      (gen_pi),
    .last    (gen_last),
    .size    (gen_size)
  );

  always_comb begin
    wr_bank_st = wsel_q ? bank1_q : bank0_q;
    rd_bank_st = rsel_q ? bank1_q : bank0_q;
    rk         = bsize_q[rsel_q] ? K_LARGE : K_SMALL;
    in_ready   = (wr_state_q == W_FILL) || (wr_state_q == W_IDLE && wr_bank_st == EMPTY);
    accept     = data_valid && in_ready;
    gen_init   = accept && blk_start;
    gen_adv    = accept && !blk_start && (wr_state_q == W_FILL);
    we         = gen_init || gen_adv;
    waddr      = blk_start ? '0 : gen_pi;
    fill_done  = gen_adv && gen_last;

    wr_state_d = wr_state_q;
    wsel_d     = wsel_q;
    bank0_d    = bank0_q;
    bank1_d    = bank1_q;
    bsize_d    = bsize_q;
    err_d      = 1'b0;
    if (gen_init) begin
      wr_state_d = W_FILL;
      err_d      = (wr_state_q == W_FILL);
    end else if (fill_done) begin
      wr_state_d       = W_IDLE;
      wsel_d           = !wsel_q;
      bsize_d[wsel_q]  = gen_size;
      if (wsel_q) bank1_d = FULL;
      else        bank0_d = FULL;
    end

    // the reader only ever frees the bank the writer is not filling
    rd_state_d   = rd_state_q;
    rsel_d       = rsel_q;
    raddr_d      = raddr_q;
    data_out_d   = 1'b0;
    data_ready_d = 1'b0;
    out_start_d  = 1'b0;
    done_d       = 1'b0;
    if (rd_state_q == R_IDLE) begin
      if (rd_bank_st == FULL) begin
        rd_state_d = R_DRAIN;
        raddr_d    = '0;
      end
    end else begin
      data_out_d   = rsel_q ? bank1_mem[raddr_q] : bank0_mem[raddr_q];
      data_ready_d = 1'b1;
      out_start_d  = (raddr_q == '0);
      done_d       = (raddr_q == rk - AW'(1));
      raddr_d      = raddr_q + AW'(1);
      if (raddr_q == rk - AW'(1)) begin
        rd_state_d = R_IDLE;
        rsel_d     = !rsel_q;
        if (rsel_q) bank1_d = EMPTY;
        else        bank0_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && we) begin
      if (wsel_q) bank1_mem[waddr] <= data_in;
      else        bank0_mem[waddr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q   <= W_IDLE;
      rd_state_q   <= R_IDLE;
      bank0_q      <= EMPTY;
      bank1_q      <= EMPTY;
      bsize_q      <= '0;
      wsel_q       <= 1'b0;
      rsel_q       <= 1'b0;
      raddr_q      <= '0;
      data_out_q   <= 1'b0;
      data_ready_q <= 1'b0;
      out_start_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      bank0_q      <= bank0_d;
      bank1_q      <= bank1_d;
      bsize_q      <= bsize_d;
      wsel_q       <= wsel_d;
      rsel_q       <= rsel_d;
      raddr_q      <= raddr_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
      out_start_q  <= out_start_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_ready = data_ready_q;
  assign out_start  = out_start_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
